// File: rtl/instr_enc16_loader_if.sv
// Host/memory side bundle for the 16-bit instruction encoder/loader.
// master = host request + memory ack driver, slave = the loader itself.
interface instr_enc16_loader_if #(parameter int AW = 8);
    logic          start;
    logic [AW-1:0] start_addr;
    logic          in_valid;
    logic          in_ready;
    logic [24:0]   op_sel;
    logic [2:0]    rd;
    logic [2:0]    rm;
    logic [2:0]    rn;
    logic [10:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic          full;
    logic          err;
    logic [AW:0]   word_cnt;

    modport master (
        output start, start_addr, in_valid, op_sel, rd, rm, rn, imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, full, err, word_cnt
    );

    modport slave (
        input  start, start_addr, in_valid, op_sel, rd, rm, rn, imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, full, err, word_cnt
    );
endinterface

// File: rtl/instr_enc16_loader.sv
// Encodes one-hot ops into 16-bit words and writes them sequentially to instruction RAM.
// Latency: word written 1 cycle after accept, min 2 cycles/word; waits on mem_ack with mem_we held.
// Backpressure: in_ready low while writing and after HLT/full. IMM_RANGE_CHK_EN rejects out-of-field imm.
module instr_enc16_loader #(
    parameter int AW = 8
) (
    input logic                  CLK,
    input logic                  RST,
    instr_enc16_loader_if.slave  bus
);
    localparam int OP_LHI  = 0,  OP_LLI  = 1,  OP_LDRI = 2,  OP_STRI = 3,  OP_ADDI = 4;
    localparam int OP_SUBI = 5,  OP_LDRR = 6,  OP_STRR = 7,  OP_CMP  = 8,  OP_ADD  = 9;
    localparam int OP_ADC  = 10, OP_SUB  = 11, OP_SBB  = 12, OP_MOV  = 13, OP_BEQ  = 14;
    localparam int OP_BNE  = 15, OP_BCS  = 16, OP_BCC  = 17, OP_BAL  = 18, OP_JMP  = 19;
    localparam int OP_JALL = 20, OP_JALR = 21, OP_JR   = 22, OP_OUTR = 23, OP_HLT  = 24;

`ifdef IMM_RANGE_CHK_EN
    localparam bit IMM_CHK = 1'b1;
`else
    localparam bit IMM_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, FULL} state_t;
    state_t state;

    logic [15:0] enc;
    logic [3:0]  fw;
    logic        onehot;
    logic        imm_over;
    logic        legal;
    logic        wr_hlt;

    // fw is the immediate field width of the selected format (0 = no immediate)
    always_comb begin
        enc = '0;
        fw  = 4'd0;
        case (1'b1)
            bus.op_sel[OP_LHI]:  begin enc = {5'b00001, bus.rd, bus.imm[7:0]};                 fw = 4'd8;  end
            bus.op_sel[OP_LLI]:  begin enc = {5'b00010, bus.rd, bus.imm[7:0]};                 fw = 4'd8;  end
            bus.op_sel[OP_LDRI]: begin enc = {5'b00011, bus.rd, bus.rm, bus.imm[4:0]};         fw = 4'd5;  end
            bus.op_sel[OP_STRI]: begin enc = {5'b00101, bus.rd, bus.rm, bus.imm[4:0]};         fw = 4'd5;  end
            bus.op_sel[OP_ADDI]: begin enc = {5'b00111, bus.rd, bus.rm, bus.imm[4:0]};         fw = 4'd5;  end
            bus.op_sel[OP_SUBI]: begin enc = {5'b01000, bus.rd, bus.rm, bus.imm[4:0]};         fw = 4'd5;  end
            bus.op_sel[OP_LDRR]: enc = {5'b00100, bus.rd, bus.rm, bus.rn, 2'b00};
            bus.op_sel[OP_STRR]: enc = {5'b00110, bus.rd, bus.rm, bus.rn, 2'b00};
            bus.op_sel[OP_CMP]:  enc = {5'b00110, 3'b000, bus.rm, bus.rn, 2'b01};
            bus.op_sel[OP_ADD]:  enc = {5'b00000, bus.rd, bus.rm, bus.rn, 2'b00};
            bus.op_sel[OP_ADC]:  enc = {5'b00000, bus.rd, bus.rm, bus.rn, 2'b01};
            bus.op_sel[OP_SUB]:  enc = {5'b00000, bus.rd, bus.rm, bus.rn, 2'b10};
            bus.op_sel[OP_SBB]:  enc = {5'b00000, bus.rd, bus.rm, bus.rn, 2'b11};
            bus.op_sel[OP_MOV]:  enc = {5'b01011, bus.rd, bus.rm, 5'b00000};
            bus.op_sel[OP_BEQ]:  begin enc = {4'b1100, 4'b0000, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_BNE]:  begin enc = {4'b1100, 4'b0001, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_BCS]:  begin enc = {4'b1100, 4'b0010, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_BCC]:  begin enc = {4'b1100, 4'b0011, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_BAL]:  begin enc = {4'b1100, 4'b1110, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_JMP]:  begin enc = {5'b10000, bus.imm};                             fw = 4'd11; end
            bus.op_sel[OP_JALL]: begin enc = {5'b10001, bus.rd, bus.imm[7:0]};                fw = 4'd8;  end
            bus.op_sel[OP_JALR]: enc = {5'b10010, bus.rd, bus.rm, 5'b00000};
            bus.op_sel[OP_JR]:   enc = {5'b10011, bus.rd, 8'h00};
            bus.op_sel[OP_OUTR]: enc = {5'b11100, 3'b000, bus.rm, 5'b00000};
            bus.op_sel[OP_HLT]:  enc = 16'hE001;
            default:             enc = '0;
        endcase
    end

    assign onehot   = (bus.op_sel != '0) && ((bus.op_sel & (bus.op_sel - 25'd1)) == '0);
    assign imm_over = |(bus.imm >> fw);
    assign legal    = onehot && !(IMM_CHK && imm_over);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            wr_hlt        <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.full      <= 1'b0;
            bus.err       <= 1'b0;
            bus.word_cnt  <= '0;
        end else if (bus.start && state != WRITE) begin
            // a start also drops any request offered in the same cycle
            state        <= LOAD;
            bus.mem_addr <= bus.start_addr;
            bus.word_cnt <= '0;
            bus.err      <= 1'b0;
            bus.done     <= 1'b0;
            bus.full     <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (!legal) begin
                            bus.err <= 1'b1;
                        end else begin
                            bus.mem_wdata <= enc;
                            wr_hlt        <= bus.op_sel[OP_HLT];
                            bus.mem_we    <= 1'b1;
                            bus.in_ready  <= 1'b0;
                            state         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        bus.mem_we   <= 1'b0;
                        bus.word_cnt <= bus.word_cnt + (AW+1)'(1);
                        if (wr_hlt) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else if (bus.mem_addr == '1) begin
                            state    <= FULL;
                            bus.full <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.mem_addr <= bus.mem_addr + AW'(1);
                            bus.in_ready <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_enc16_loader.sv
// Table-driven encode/write checks with a write scoreboard, plus hand sequences for corner cases.
module tb_instr_enc16_loader;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    instr_enc16_loader_if #(.AW(8)) b8();
    instr_enc16_loader_if #(.AW(4)) b4();
    instr_enc16_loader #(.AW(8)) dut8 (.CLK(CLK), .RST(RST), .bus(b8));
    instr_enc16_loader #(.AW(4)) dut4 (.CLK(CLK), .RST(RST), .bus(b4));

    localparam int LHI = 0,  LLI = 1,  LDRI = 2,  STRI = 3,  ADDI = 4,  SUBI = 5,  LDRR = 6;
    localparam int STRR = 7, CMP = 8,  ADD = 9,   ADC = 10,  SUB = 11,  SBB = 12,  MOV = 13;
    localparam int BEQ = 14, BNE = 15, BCS = 16,  BCC = 17,  BAL = 18,  JMP = 19,  JALL = 20;
    localparam int JALR = 21, JR = 22, OUTR = 23, HLT = 24;

    typedef struct {
        int          op;
        logic [2:0]  rd, rm, rn;
        logic [10:0] imm;
        logic [15:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    vec_t vt [13];
    wr_t  sb [$];
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_addr;
    int   exp_cnt;

    function automatic logic [24:0] oh(input int op);
        return 25'd1 << op;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic req8(input logic [24:0] sel, input logic [2:0] rd, input logic [2:0] rm,
                        input logic [2:0] rn, input logic [10:0] imm);
        b8.op_sel = sel; b8.rd = rd; b8.rm = rm; b8.rn = rn; b8.imm = imm;
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
    endtask

    task automatic do_write8(input int op, input logic [2:0] rd, input logic [2:0] rm,
                             input logic [2:0] rn, input logic [10:0] imm, input int dly,
                             input logic [15:0] exp);
        wr_t got, e;
        sb.push_back({exp_addr, exp});
        req8(oh(op), rd, rm, rn, imm);
        if (b8.mem_we !== 1'b1) begin
            chk("we_assert", 32'(b8.mem_we), 32'd1);
            void'(sb.pop_back());
            return;
        end
        chk("rdy_low", 32'(b8.in_ready), 32'd0);
        got = {b8.mem_addr, b8.mem_wdata};
        for (int i = 0; i < dly; i++) begin
            chk("hold", 32'({b8.mem_we, b8.in_ready, b8.mem_addr, b8.mem_wdata}),
                32'({1'b1, 1'b0, got}));
            tick();
        end
        b8.mem_ack = 1'b1;
        tick();
        b8.mem_ack = 1'b0;
        e = sb.pop_front();
        chk("wdata", 32'(got.data), 32'(e.data));
        chk("waddr", 32'(got.addr), 32'(e.addr));
        chk("we_drop", 32'(b8.mem_we), 32'd0);
        chk("rdy_after", 32'(b8.in_ready), (op == HLT) ? 32'd0 : 32'd1);
        exp_addr++;
        exp_cnt++;
        chk("word_cnt", 32'(b8.word_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{ADD,  3'd7, 3'd5, 3'd0, 11'h000, 16'h07A0};
        vt[1]  = '{BAL,  3'd0, 3'd0, 3'd0, 11'h0FF, 16'hCEFF};
        vt[2]  = '{JMP,  3'd0, 3'd0, 3'd0, 11'h7FF, 16'h87FF};
        vt[3]  = '{CMP,  3'd3, 3'd5, 3'd0, 11'h000, 16'h30A1};
        vt[4]  = '{LLI,  3'd3, 3'd0, 3'd0, 11'h05C, 16'h135C};
        vt[5]  = '{SUB,  3'd1, 3'd2, 3'd3, 11'h000, 16'h014E};
        vt[6]  = '{MOV,  3'd2, 3'd6, 3'd0, 11'h000, 16'h5AC0};
        vt[7]  = '{JR,   3'd5, 3'd0, 3'd0, 11'h000, 16'h9D00};
        vt[8]  = '{STRI, 3'd4, 3'd1, 3'd0, 11'h013, 16'h2C33};
        vt[9]  = '{BNE,  3'd0, 3'd0, 3'd0, 11'h080, 16'hC180};
        vt[10] = '{JALL, 3'd6, 3'd0, 3'd0, 11'h012, 16'h8E12};
        vt[11] = '{OUTR, 3'd0, 3'd7, 3'd0, 11'h000, 16'hE0E0};
        vt[12] = '{ADC,  3'd0, 3'd0, 3'd7, 11'h000, 16'h001D};

        b8.start = 0; b8.start_addr = '0; b8.in_valid = 0; b8.op_sel = '0;
        b8.rd = '0; b8.rm = '0; b8.rn = '0; b8.imm = '0; b8.mem_ack = 0;
        b4.start = 0; b4.start_addr = '0; b4.in_valid = 0; b4.op_sel = '0;
        b4.rd = '0; b4.rm = '0; b4.rn = '0; b4.imm = '0; b4.mem_ack = 0;
        RST = 1'b1;
        tick();
        tick();
        chk("rst_we_rdy", 32'({b8.mem_we, b8.in_ready}), 32'd0);
        chk("rst_addr", 32'(b8.mem_addr), 32'd0);
        chk("rst_wdata", 32'(b8.mem_wdata), 32'd0);
        chk("rst_cnt", 32'(b8.word_cnt), 32'd0);
        chk("rst_flags", 32'({b8.busy, b8.done, b8.full, b8.err}), 32'd0);
        RST = 1'b0;
        tick();

        b8.start = 1'b1; b8.start_addr = 8'h10;
        tick();
        b8.start = 1'b0;
        chk("start_state", 32'({b8.in_ready, b8.busy, b8.mem_addr}), 32'({1'b1, 1'b1, 8'h10}));
        exp_addr = 8'h10;
        exp_cnt  = 0;

        for (int i = 0; i < 13; i++)
            do_write8(vt[i].op, vt[i].rd, vt[i].rm, vt[i].rn, vt[i].imm, i % 3, vt[i].exp);

        do_write8(LHI, 3'd0, 3'd0, 3'd0, 11'h0AA, 3, 16'h08AA);

        req8(25'h0000003, 3'd1, 3'd1, 3'd1, 11'h0);
        chk("illegal_err", 32'(b8.err), 32'd1);
        chk("illegal_nowe", 32'(b8.mem_we), 32'd0);
        chk("illegal_cnt", 32'(b8.word_cnt), 32'(exp_cnt));
        chk("illegal_rdy", 32'(b8.in_ready), 32'd1);

        b8.start = 1'b1; b8.start_addr = 8'h40;
        b8.op_sel = oh(ADD); b8.in_valid = 1'b1;
        tick();
        b8.start = 1'b0; b8.in_valid = 1'b0;
        chk("startwin_we", 32'(b8.mem_we), 32'd0);
        chk("startwin_st", 32'({b8.mem_addr, b8.err, b8.in_ready}), 32'({8'h40, 1'b0, 1'b1}));
        chk("startwin_cnt", 32'(b8.word_cnt), 32'd0);
        exp_addr = 8'h40;
        exp_cnt  = 0;

        req8(25'h0, 3'd0, 3'd0, 3'd0, 11'h0);
        chk("zero_op_err", 32'({b8.err, b8.in_ready, b8.mem_we}), 32'({1'b1, 1'b1, 1'b0}));

        do_write8(HLT, 3'd0, 3'd0, 3'd0, 11'h0, 1, 16'hE001);
        chk("hlt_flags", 32'({b8.done, b8.busy, b8.err, b8.full}), 32'({1'b1, 1'b0, 1'b1, 1'b0}));
        req8(oh(ADD), 3'd1, 3'd1, 3'd1, 11'h0);
        chk("done_ignores", 32'({b8.mem_we, b8.in_ready}), 32'd0);

        b8.start = 1'b1; b8.start_addr = 8'h20;
        tick();
        b8.start = 1'b0;
        chk("restart_clr", 32'({b8.done, b8.err, b8.in_ready}), 32'({1'b0, 1'b0, 1'b1}));

        req8(oh(SUB), 3'd1, 3'd2, 3'd3, 11'h0);
        b8.start = 1'b1; b8.start_addr = 8'h55;
        tick();
        b8.start = 1'b0;
        chk("start_in_write", 32'({b8.mem_we, b8.mem_addr}), 32'({1'b1, 8'h20}));
        b8.mem_ack = 1'b1;
        tick();
        b8.mem_ack = 1'b0;
        chk("after_ignored_start", 32'({b8.mem_addr, b8.word_cnt}), 32'({8'h21, 9'd1}));

        req8(oh(MOV), 3'd1, 3'd2, 3'd0, 11'h0);
        chk("pre_rst_we", 32'(b8.mem_we), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_we", 32'({b8.mem_we, b8.in_ready, b8.mem_addr}), 32'd0);
        RST = 1'b0;
        tick();

        b4.start = 1'b1; b4.start_addr = 4'hF;
        tick();
        b4.start = 1'b0;
        b4.op_sel = oh(LLI); b4.rd = 3'd3; b4.imm = 11'h05C; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        chk("aw4_write", 32'({b4.mem_we, b4.mem_addr, b4.mem_wdata}), 32'({1'b1, 4'hF, 16'h135C}));
        b4.mem_ack = 1'b1;
        tick();
        b4.mem_ack = 1'b0;
        chk("aw4_full", 32'({b4.full, b4.in_ready, b4.busy, b4.done}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
        chk("aw4_nowrap", 32'({b4.mem_addr, b4.word_cnt}), 32'({4'hF, 5'd1}));

        b4.start = 1'b1; b4.start_addr = 4'h0;
        tick();
        b4.start = 1'b0;
        b4.op_sel = oh(ADDI); b4.rd = 3'd1; b4.rm = 3'd4; b4.imm = 11'h020; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
`ifdef IMM_RANGE_CHK_EN
        chk("addi_range_err", 32'({b4.err, b4.mem_we, b4.in_ready}), 32'({1'b1, 1'b0, 1'b1}));
`else
        chk("addi_trunc", 32'({b4.err, b4.mem_we, b4.mem_wdata}), 32'({1'b0, 1'b1, 16'h3980}));
        b4.mem_ack = 1'b1;
        tick();
        b4.mem_ack = 1'b0;
        chk("addi_cnt", 32'({b4.word_cnt, b4.mem_addr}), 32'({5'd1, 4'h1}));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_enc16_loader.md
Name: instr_enc16_loader

Overview:
Program loader that encodes one-hot operation selects plus operand fields into 16-bit instruction words and writes them sequentially into instruction memory. It is the encoder counterpart of InstrDec16: every word it writes decodes back to the same 25-bit one-hot OP. It sits between a host/debug port and the instruction RAM and is used for boot-time program load.

Parameters:
AW, 8, instruction memory address width; capacity 2^AW words.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
start  in  1  begin a load session at start_addr
start_addr  in  AW  first write address
in_valid  in  1  operation request valid
in_ready  out  1  loader accepts request this cycle
op_sel  in  25  one-hot op, bit order = InstrDec16 OP (bit0 LHI … bit24 HLT)
rd  in  3  destination/first register field
rm  in  3  second register field
rn  in  3  third register field
imm  in  11  immediate / displacement, low bits used per format
mem_we  out  1  memory write request
mem_addr  out  AW  write address
mem_wdata  out  16  encoded instruction
mem_ack  in  1  memory accepted write (sampled while mem_we=1)
busy  out  1  state is LOAD or WRITE
done  out  1  HLT written, session closed
full  out  1  last address written, session closed
err  out  1  sticky: illegal request rejected
word_cnt  out  AW+1  words written this session

Behaviour:
- Encoding [15:11]/[10:8]/[7:5]/[4:2]/[1:0]:
  LHI 00001,rd,imm8; LLI 00010,rd,imm8.
  LDRi 00011,rd,rm,imm5; STRi 00101,rd,rm,imm5; ADDI 00111,rd,rm,imm5; SUBI 01000,rd,rm,imm5.
  LDRr 00100,rd,rm,rn,00; STRr 00110,rd,rm,rn,00; CMP 00110,000,rm,rn,01.
  ADD/ADC/SUB/SBB 00000,rd,rm,rn,00/01/10/11.
  MOV 01011,rd,rm,00000.
  Branches 1100,cond[11:8],imm8: BEQ 0000, BNE 0001, BCS 0010, BCC 0011, BAL 1110.
  JMP 10000,imm11; JAL label 10001,rd,imm8; JAL reg 10010,rd,rm,00000; JR 10011,rd,00000000.
  OutR 11100,000,rm,000,00; HLT 11100,000,000,000,01.
  Unused fields forced 0.
- States: IDLE, LOAD, WRITE, DONE, FULL.
- Reset: IDLE; all outputs 0; mem_addr=0, mem_wdata=0, word_cnt=0.
- start honoured in IDLE, LOAD, DONE, FULL; ignored in WRITE. On start: mem_addr<=start_addr, word_cnt<=0, err/done/full<=0, ->LOAD.
- LOAD: in_ready=1. On in_valid: if op_sel is not exactly one-hot (zero or >1 bit), set err, no write, stay LOAD. Else register the encoded word, assert mem_we next cycle, ->WRITE.
- WRITE: in_ready=0. mem_we, mem_addr and mem_wdata held stable until mem_ack=1; mem_ack in the first mem_we cycle is legal. Minimum 2 cycles per word.
- On ack: mem_we<=0, word_cnt++; if word was HLT ->DONE (done=1); else if mem_addr==2^AW-1 ->FULL (full=1, no wrap); else mem_addr++ and ->LOAD.
- DONE/FULL: in_ready=0 until next start.
- Simultaneous start with accepted in_valid in LOAD: start wins, request dropped.
- RST mid-WRITE: mem_we deasserts immediately (asynchronous).

Optional Feature:
IMM_RANGE_CHK_EN: defined -> a nonzero imm bit above the format's field width (imm5/imm8/imm11), or nonzero imm for non-immediate ops, is treated as illegal (err=1, no write). Undefined -> imm silently truncated to field width, no error.

Test Plan:
- start, start_addr=0x10; ADD rd=7 rm=5 rn=0; mem_ack in the first mem_we cycle -> mem_addr=0x10, mem_wdata=0x07A0, word_cnt=1, in_ready back high 2 cycles after accept.
- LHI rd=0 imm=0x0AA, mem_ack delayed 3 cycles -> mem_we held 4 cycles, wdata=0x08AA stable, in_ready=0 throughout.
- BAL imm=0x0FF -> 0xCEFF; JMP imm=0x7FF -> 0x87FF; CMP rm=5 rn=0 -> 0x30A1.
- op_sel=0x0000003 -> err=1, no mem_we, word_cnt unchanged, in_ready stays 1.
- HLT -> 0xE001 written, done=1, in_ready=0; a new start clears done and err.
- AW=4, start_addr=0xF, one LLI -> full=1, in_ready=0. ADDI rd=1 rm=4 imm=0x20: with IMM_RANGE_CHK_EN -> err=1, no write; without it -> 0x3980 written.
